// File: rtl/axi_wr_arbiter.sv
// Round-robin arbiter giving NUM_M AXI write masters shared access to one slave.
// Latency: request in cycle N gives s_awvalid in N+1; AW/W/B are then forwarded combinationally.
// Backpressure: the granted master sees slave readies directly; every other master sees ready=0.
module axi_wr_arbiter #(
    parameter int NUM_M = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NUM_M-1:0]     m_awvalid,
    output logic [NUM_M-1:0]     m_awready,
    input  logic [45*NUM_M-1:0]  m_aw_pl,
    input  logic [NUM_M-1:0]     m_wvalid,
    output logic [NUM_M-1:0]     m_wready,
    input  logic [36*NUM_M-1:0]  m_w_pl,
    input  logic [NUM_M-1:0]     m_wlast,
    output logic [NUM_M-1:0]     m_bvalid,
    input  logic [NUM_M-1:0]     m_bready,
    output logic [5:0]           m_b_pl,
    output logic                 s_awvalid,
    input  logic                 s_awready,
    output logic [44:0]          s_aw_pl,
    output logic                 s_wvalid,
    input  logic                 s_wready,
    output logic [35:0]          s_w_pl,
    output logic [3:0]           s_wid,
    output logic                 s_wlast,
    input  logic                 s_bvalid,
    output logic                 s_bready,
    input  logic [5:0]           s_b_pl,
    output logic [NUM_M-1:0]     grant,
    output logic                 wlast_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    logic [1:0]       state;
    logic [1:0]       ptr;
    logic [1:0]       ptr_nxt;
    logic [3:0]       len;
    logic [3:0]       cnt;
    logic [NUM_M-1:0] pick;
    logic             pick_vld;
    logic             sel_awvalid;
    logic [44:0]      sel_aw_pl;
    logic             sel_wvalid;
    logic [35:0]      sel_w_pl;
    logic             sel_wlast;
    logic             sel_bready;
    logic             last_beat;
    logic             aw_hs;
    logic             w_hs;
    logic             b_hs;

    assign last_beat = (cnt == len);

    // Round-robin pick: first requester at or after the pointer, wrapping.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        for (int k = 0; k < NUM_M; k++) begin
            for (int j = 0; j < NUM_M; j++) begin
                if (!pick_vld && m_awvalid[j] && (j == ((int'(ptr) + k) % NUM_M))) begin
                    pick     = '0;
                    pick[j]  = 1'b1;
                    pick_vld = 1'b1;
                end
            end
        end
    end

    // Select the granted master's channels; grant is one-hot so at most one match.
    always_comb begin
        sel_awvalid = 1'b0;
        sel_aw_pl   = '0;
        sel_wvalid  = 1'b0;
        sel_w_pl    = '0;
        sel_wlast   = 1'b0;
        sel_bready  = 1'b0;
        ptr_nxt     = ptr;
        for (int j = 0; j < NUM_M; j++) begin
            if (grant[j]) begin
                sel_awvalid = m_awvalid[j];
                sel_aw_pl   = m_aw_pl[45*j +: 45];
                sel_wvalid  = m_wvalid[j];
                sel_w_pl    = m_w_pl[36*j +: 36];
                sel_wlast   = m_wlast[j];
                sel_bready  = m_bready[j];
                ptr_nxt     = 2'((j + 1) % NUM_M);
            end
        end
    end

    // Channel forwarding, gated by phase so idle channels read as zero.
    always_comb begin
        s_awvalid = 1'b0;
        s_aw_pl   = '0;
        m_awready = '0;
        s_wvalid  = 1'b0;
        s_w_pl    = '0;
        s_wlast   = 1'b0;
        m_wready  = '0;
        m_bvalid  = '0;
        s_bready  = 1'b0;
        m_b_pl    = '0;
        case (state)
            ST_ADDR: begin
                s_awvalid = sel_awvalid;
                s_aw_pl   = sel_aw_pl;
                m_awready = grant & {NUM_M{s_awready}};
            end
            ST_DATA: begin
                s_wvalid  = sel_wvalid;
                s_w_pl    = sel_w_pl;
                s_wlast   = last_beat;
                m_wready  = grant & {NUM_M{s_wready}};
            end
            ST_RESP: begin
                m_bvalid  = grant & {NUM_M{s_bvalid}};
                s_bready  = sel_bready;
                m_b_pl    = s_b_pl;
            end
            default: ;
        endcase
    end

    assign aw_hs = s_awvalid & s_awready;
    assign w_hs  = s_wvalid & s_wready;
    assign b_hs  = s_bvalid & s_bready;

    // Transaction sequencing: arbitrate, address, data beats, response.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            grant     <= '0;
            ptr       <= '0;
            s_wid     <= '0;
            len       <= '0;
            cnt       <= '0;
            wlast_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_vld) begin
                        grant <= pick;
                        state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (aw_hs) begin
                        s_wid <= sel_aw_pl[44:41];
                        len   <= sel_aw_pl[40:37];
                        cnt   <= '0;
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_hs) begin
                        cnt <= cnt + 4'd1;
                        // Master's WLAST is only audited; the burst length comes from AWLEN.
                        if (sel_wlast != last_beat) begin
                            wlast_err <= 1'b1;
                        end
                        if (last_beat) begin
                            state <= ST_RESP;
                        end
                    end
                end
                default: begin
                    if (b_hs) begin
                        ptr   <= ptr_nxt;
                        grant <= '0;
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/axi_wr_arbiter.md
Name: axi_wr_arbiter

Overview:
Round-robin arbiter sharing one AXI write path (AW/W/B channels, 4-bit IDs, 32-bit data) between NUM_M masters and a single memory slave. Grant is held for a whole transaction: AW handshake, all W beats, then the B handshake. The slave's WID and WLAST are regenerated from the captured AW, so the slave always sees a well-formed burst.

Parameters:
NUM_M, 2, number of masters (2..4).

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
m_awvalid  in  NUM_M  per-master AW valid
m_awready  out  NUM_M  per-master AW ready
m_aw_pl  in  45*NUM_M  per-master {awid[3:0],awlen[3:0],awsize[2:0],awburst[1:0],awaddr[31:0]}, master i at [45*i+:45]
m_wvalid  in  NUM_M  per-master W valid
m_wready  out  NUM_M  per-master W ready
m_w_pl  in  36*NUM_M  per-master {wdata[31:0],wstrb[3:0]}
m_wlast  in  NUM_M  per-master WLAST (checked only)
m_bvalid  out  NUM_M  per-master B valid
m_bready  in  NUM_M  per-master B ready
m_b_pl  out  6  {bid[3:0],bresp[1:0]}, broadcast to all masters
s_awvalid  out  1  slave AW valid
s_awready  in  1  slave AW ready
s_aw_pl  out  45  granted master's AW payload
s_wvalid  out  1  slave W valid
s_wready  in  1  slave W ready
s_w_pl  out  36  granted master's W payload
s_wid  out  4  captured awid
s_wlast  out  1  generated WLAST
s_bvalid  in  1  slave B valid
s_bready  out  1  slave B ready
s_b_pl  in  6  slave {bid,bresp}
grant  out  NUM_M  one-hot current grant, 0 when IDLE
wlast_err  out  1  sticky: master WLAST disagreed with the beat count

Behaviour:
- Reset (resetn low, asynchronous):
  - Go to IDLE.
  - All outputs 0: every valid, every ready, grant, wlast_err, s_wid.
  - Round-robin pointer set so master 0 has highest priority.
  - Beat counter 0.
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE:
  - If any m_awvalid is high, pick the first requester at or after the pointer (wrapping modulo NUM_M).
  - Register the one-hot grant and move to ADDR on the next edge. No combinational path from m_awvalid to s_awvalid in IDLE.
  - Latency: request seen in cycle N gives s_awvalid in cycle N+1.
- ADDR:
  - s_awvalid = m_awvalid[g]; s_aw_pl = m_aw_pl[g]; m_awready[g] = s_awready. All other ready bits stay 0.
  - On the handshake: capture awid into s_wid and awlen into len; clear the beat counter; move to DATA.
- DATA:
  - s_wvalid = m_wvalid[g]; s_w_pl = m_w_pl[g]; m_wready[g] = s_wready.
  - s_wlast = (cnt == len), combinational.
  - On each W handshake, cnt increments (4-bit).
  - On the handshake with cnt == len, move to RESP. len=0 is a single beat; len=15 is 16 beats with no counter overflow.
  - If a handshake has m_wlast[g] != (cnt == len), set wlast_err. It stays set until reset and does not alter the burst.
- RESP:
  - m_bvalid[g] = s_bvalid; s_bready = m_bready[g]; m_b_pl = s_b_pl.
  - On the handshake, move to IDLE, set pointer = g+1 (mod NUM_M) and clear grant.
- AW accepted before data: W beats from any master are not accepted until ADDR completes; m_wready stays 0.
- One transaction at a time: new requests wait in IDLE and are not granted while DATA or RESP is active.
- Simultaneous requests: resolved purely by the pointer.
- Master dropping awvalid in ADDR: grant is held and the FSM waits; no re-arbitration.
- Reset mid-transaction: immediate return to IDLE. The in-flight burst is abandoned without completion.

Test Plan:
- Single write, NUM_M=2: m0 sends awaddr=0x100, awlen=3, awid=5, with 4 beats -> s_awvalid one cycle after m0 awvalid; s_wid=5; s_wlast on beat 4 only; m0 bvalid with bid=5; grant=01 then 00.
- Contention: m0 and m1 raise awvalid in the same cycle after reset -> m0 served first, then m1; with both requesting again, m1 is not starved and order alternates m0,m1,m0.
- Backpressure: s_awready and s_wready randomly low, awlen=15 -> exactly 16 W handshakes; no beat lost or duplicated; data order preserved.
- WLAST checks: m1 asserts wlast on beat 2 of an awlen=3 burst -> wlast_err=1 and the burst still completes 4 beats. A separate awlen=0 burst -> s_wlast on its first beat.
- Isolation: m1 presents wvalid while m0 holds the grant -> m_wready[1]=0 and m_bvalid[1]=0 throughout.
- Reset mid-burst: resetn low after 2 of 4 beats -> all outputs 0 asynchronously; grant=00; after release, m1 and m0 request together -> m0 is granted.
